// File: rtl/vermibus_router_pkg.sv
// Shared constants and types for the Vermibus router and its address decoder.
package vermibus_router_pkg;

    localparam int DEV_TAG_BITS = 8;
    localparam int DEV_TAG_LSB  = 24;

    localparam logic [31:0] DEFAULT_RDATA_C = 32'h0000_0000;
    localparam logic [31:0] ERROR_RDATA_C   = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ABORT = 2'd2
    } router_state_t;

endpackage

// File: rtl/vermibus_addr_decoder.sv
// Combinational tag decoder: maps an address tag to {hit, index}; on duplicate tags the lowest index wins.
module vermibus_addr_decoder
    import vermibus_router_pkg::*;
#(
    parameter int                      N_DEVICES = 3,
    parameter int                      IDX_W     = 2,
    parameter logic [DEV_TAG_BITS-1:0] DEV_ADDRESS [N_DEVICES] = '{8'h00, 8'h10, 8'h20}
) (
    input  logic [DEV_TAG_BITS-1:0] tag,
    output logic                    hit,
    output logic [IDX_W-1:0]        index
);

    // Scanning downward lets the lowest matching index overwrite any higher one.
    always_comb begin
        hit   = 1'b0;
        index = '0;
        for (int i = N_DEVICES - 1; i >= 0; i--) begin
            if (tag == DEV_ADDRESS[i]) begin
                hit   = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/vermibus_router.sv
// Vermibus interconnect: one manager to N_DEVICES subordinates, routed by address[31:24].
// Optional stall abort is enabled by defining VERMIBUS_ROUTER_TIMEOUT_EN.
module vermibus_router
    import vermibus_router_pkg::*;
#(
    parameter int                      N_DEVICES      = 3,
    parameter logic [DEV_TAG_BITS-1:0] DEV_ADDRESS [N_DEVICES] = '{8'h00, 8'h10, 8'h20},
    parameter int                      TIMEOUT_CYCLES = 256,
    parameter logic [31:0]             DEFAULT_RDATA  = DEFAULT_RDATA_C,
    parameter logic [31:0]             ERROR_RDATA    = ERROR_RDATA_C
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       m_valid,
    input  logic [31:0]                m_address,
    input  logic [3:0]                 m_wstrobe,
    input  logic [31:0]                m_wdata,
    output logic [31:0]                m_rdata,
    output logic                       m_ready,
    output logic [N_DEVICES-1:0]       s_valid,
    output logic [31:0]                s_address,
    output logic [3:0]                 s_wstrobe,
    output logic [31:0]                s_wdata,
    input  logic [N_DEVICES-1:0][31:0] s_rdata,
    input  logic [N_DEVICES-1:0]       s_ready,
    output logic                       err_unmapped,
    output logic                       err_timeout,
    input  logic                       err_clear
);

    localparam int IDX_W = (N_DEVICES > 1) ? $clog2(N_DEVICES) : 1;

    router_state_t    state, next_state;
    logic [IDX_W-1:0] sel_q;
    logic [IDX_W-1:0] dec_index;
    logic             dec_hit;
    logic             set_unmapped;
    logic             start_wait;
    logic             wait_stall;

    assign s_address = m_address;
    assign s_wstrobe = m_wstrobe;
    assign s_wdata   = m_wdata;

    vermibus_addr_decoder #(
        .N_DEVICES   (N_DEVICES),
        .IDX_W       (IDX_W),
        .DEV_ADDRESS (DEV_ADDRESS)
    ) u_decoder (
        .tag   (m_address[DEV_TAG_LSB +: DEV_TAG_BITS]),
        .hit   (dec_hit),
        .index (dec_index)
    );

`ifdef VERMIBUS_ROUTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt;
    logic             cnt_expired;
    assign cnt_expired = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        next_state   = state;
        s_valid      = '0;
        m_ready      = 1'b0;
        m_rdata      = DEFAULT_RDATA;
        set_unmapped = 1'b0;
        start_wait   = 1'b0;
        wait_stall   = 1'b0;
        case (state)
            IDLE: begin
                if (dec_hit) begin
                    s_valid[dec_index] = m_valid;
                    m_ready            = m_valid & s_ready[dec_index];
                    m_rdata            = s_rdata[dec_index];
                    if (m_valid && !s_ready[dec_index]) begin
                        next_state = WAIT;
                        start_wait = 1'b1;
                    end
                end else begin
                    m_ready      = m_valid;
                    set_unmapped = m_valid;
                end
            end
            WAIT: begin
                // The latched target owns the bus until completion; the address is not re-decoded.
                s_valid[sel_q] = m_valid;
                m_ready        = m_valid & s_ready[sel_q];
                m_rdata        = s_rdata[sel_q];
                if (!m_valid || s_ready[sel_q]) begin
                    next_state = IDLE;
                end else begin
                    wait_stall = 1'b1;
`ifdef VERMIBUS_ROUTER_TIMEOUT_EN
                    if (cnt_expired) next_state = ABORT;
`endif
                end
            end
`ifdef VERMIBUS_ROUTER_TIMEOUT_EN
            ABORT: begin
                m_ready    = 1'b1;
                m_rdata    = ERROR_RDATA;
                next_state = IDLE;
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            sel_q        <= '0;
            err_unmapped <= 1'b0;
        end else begin
            state        <= next_state;
            if (start_wait) sel_q <= dec_index;
            err_unmapped <= set_unmapped | (err_unmapped & ~err_clear);
        end
    end

`ifdef VERMIBUS_ROUTER_TIMEOUT_EN
    // Counter saturates at all-ones so a very long stall can never wrap back below the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (start_wait) begin
                cnt <= CNT_W'(1);
            end else if (wait_stall && cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
            end
            err_timeout <= (state == ABORT) | (err_timeout & ~err_clear);
        end
    end
`else
    assign err_timeout = 1'b0;
    logic unused_stall;
    assign unused_stall = wait_stall;
`endif

endmodule

// File: tb/tb_vermibus_router.sv
// Directed self-checking bench for vermibus_router (default and VERMIBUS_ROUTER_TIMEOUT_EN builds).
module tb_vermibus_router;

    logic              clk = 1'b0;
    logic              reset;
    logic              m_valid;
    logic [31:0]       m_address;
    logic [3:0]        m_wstrobe;
    logic [31:0]       m_wdata;
    logic [31:0]       m_rdata;
    logic              m_ready;
    logic [2:0]        s_valid;
    logic [31:0]       s_address;
    logic [3:0]        s_wstrobe;
    logic [31:0]       s_wdata;
    logic [2:0][31:0]  s_rdata;
    logic [2:0]        s_ready;
    logic              err_unmapped;
    logic              err_timeout;
    logic              err_clear;

    logic [31:0]       d2_m_rdata;
    logic              d2_m_ready;
    logic [2:0]        d2_s_valid;
    logic [31:0]       d2_s_address;
    logic [3:0]        d2_s_wstrobe;
    logic [31:0]       d2_s_wdata;
    logic              d2_err_unmapped;
    logic              d2_err_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vermibus_router #(
        .N_DEVICES      (3),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .m_valid      (m_valid),
        .m_address    (m_address),
        .m_wstrobe    (m_wstrobe),
        .m_wdata      (m_wdata),
        .m_rdata      (m_rdata),
        .m_ready      (m_ready),
        .s_valid      (s_valid),
        .s_address    (s_address),
        .s_wstrobe    (s_wstrobe),
        .s_wdata      (s_wdata),
        .s_rdata      (s_rdata),
        .s_ready      (s_ready),
        .err_unmapped (err_unmapped),
        .err_timeout  (err_timeout),
        .err_clear    (err_clear)
    );

    vermibus_router #(
        .N_DEVICES      (3),
        .DEV_ADDRESS    ('{8'h00, 8'h00, 8'h10}),
        .TIMEOUT_CYCLES (4)
    ) dut_dup (
        .clk          (clk),
        .reset        (reset),
        .m_valid      (m_valid),
        .m_address    (m_address),
        .m_wstrobe    (m_wstrobe),
        .m_wdata      (m_wdata),
        .m_rdata      (d2_m_rdata),
        .m_ready      (d2_m_ready),
        .s_valid      (d2_s_valid),
        .s_address    (d2_s_address),
        .s_wstrobe    (d2_s_wstrobe),
        .s_wdata      (d2_s_wdata),
        .s_rdata      (s_rdata),
        .s_ready      (s_ready),
        .err_unmapped (d2_err_unmapped),
        .err_timeout  (d2_err_timeout),
        .err_clear    (err_clear)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; m_valid = 1'b0; m_address = 32'h0; m_wstrobe = 4'h0; m_wdata = 32'h0;
        s_ready = 3'b000; err_clear = 1'b0;
        s_rdata[0] = 32'h1234_5678; s_rdata[1] = 32'h0000_00AA; s_rdata[2] = 32'hCAFE_F00D;
        tick(); tick();
        #1;
        n_checks++; if (s_valid !== 3'b000) begin n_fail++; $display("FAIL reset_s_valid: got %b want 000", s_valid); end
        n_checks++; if (m_ready !== 1'b0) begin n_fail++; $display("FAIL reset_m_ready: got %b want 0", m_ready); end
        n_checks++; if (err_unmapped !== 1'b0) begin n_fail++; $display("FAIL reset_err_unmapped: got %b want 0", err_unmapped); end
        n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_err_timeout: got %b want 0", err_timeout); end
        reset = 1'b0;
    endtask

    task automatic test_ram_read();
        tick();
        m_valid = 1'b1; m_address = 32'h0000_0040; m_wstrobe = 4'h0; s_ready = 3'b001;
        #1;
        n_checks++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL ram_ready: got %b want 1", m_ready); end
        n_checks++; if (m_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL ram_rdata: got %h want 12345678", m_rdata); end
        n_checks++; if (s_valid !== 3'b001) begin n_fail++; $display("FAIL ram_s_valid: got %b want 001", s_valid); end
        n_checks++; if (s_address !== 32'h0000_0040) begin n_fail++; $display("FAIL ram_s_address: got %h want 00000040", s_address); end
        tick();
        m_valid = 1'b0; s_ready = 3'b000;
        #1;
        n_checks++; if (m_ready !== 1'b0) begin n_fail++; $display("FAIL ram_idle_ready: got %b want 0", m_ready); end
    endtask

    task automatic test_io_write();
        tick();
        m_valid = 1'b1; m_address = 32'h1000_0000; m_wstrobe = 4'h1; m_wdata = 32'h41; s_ready = 3'b000;
        #1;
        n_checks++; if (s_valid !== 3'b010) begin n_fail++; $display("FAIL io_req_s_valid: got %b want 010", s_valid); end
        n_checks++; if (m_ready !== 1'b0) begin n_fail++; $display("FAIL io_req_ready: got %b want 0", m_ready); end
        n_checks++; if (s_wstrobe !== 4'h1) begin n_fail++; $display("FAIL io_s_wstrobe: got %h want 1", s_wstrobe); end
        n_checks++; if (s_wdata !== 32'h41) begin n_fail++; $display("FAIL io_s_wdata: got %h want 00000041", s_wdata); end
        for (int i = 0; i < 2; i++) begin
            tick();
            if (i == 0) m_address = 32'h0000_0000;
            s_ready = (i == 1) ? 3'b001 : 3'b000;
            #1;
            n_checks++; if (s_valid !== 3'b010) begin n_fail++; $display("FAIL io_wait%0d_s_valid: got %b want 010", i, s_valid); end
            n_checks++; if (m_ready !== 1'b0) begin n_fail++; $display("FAIL io_wait%0d_ready: got %b want 0", i, m_ready); end
        end
        tick();
        s_ready = 3'b010;
        #1;
        n_checks++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL io_done_ready: got %b want 1", m_ready); end
        n_checks++; if (m_rdata !== 32'h0000_00AA) begin n_fail++; $display("FAIL io_done_rdata: got %h want 000000aa", m_rdata); end
        n_checks++; if (s_valid !== 3'b010) begin n_fail++; $display("FAIL io_done_s_valid: got %b want 010", s_valid); end
        tick();
        m_address = 32'h2000_0000; s_ready = 3'b000; m_wstrobe = 4'h0;
        #1;
        n_checks++; if (s_valid !== 3'b100) begin n_fail++; $display("FAIL io_back_idle: got %b want 100", s_valid); end
        m_valid = 1'b0;
        #1;
    endtask

    task automatic test_unmapped();
        tick();
        m_valid = 1'b1; m_address = 32'h5000_0000; m_wstrobe = 4'h0;
        #1;
        n_checks++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL unm_ready: got %b want 1", m_ready); end
        n_checks++; if (m_rdata !== 32'h0) begin n_fail++; $display("FAIL unm_rdata: got %h want 00000000", m_rdata); end
        n_checks++; if (s_valid !== 3'b000) begin n_fail++; $display("FAIL unm_s_valid: got %b want 000", s_valid); end
        n_checks++; if (err_unmapped !== 1'b0) begin n_fail++; $display("FAIL unm_flag_early: got %b want 0", err_unmapped); end
        tick();
        m_valid = 1'b0;
        #1;
        n_checks++; if (err_unmapped !== 1'b1) begin n_fail++; $display("FAIL unm_flag_set: got %b want 1", err_unmapped); end
        m_valid = 1'b1; err_clear = 1'b1;
        tick();
        m_valid = 1'b0;
        #1;
        n_checks++; if (err_unmapped !== 1'b1) begin n_fail++; $display("FAIL unm_error_wins: got %b want 1", err_unmapped); end
        tick();
        err_clear = 1'b0;
        #1;
        n_checks++; if (err_unmapped !== 1'b0) begin n_fail++; $display("FAIL unm_cleared: got %b want 0", err_unmapped); end
    endtask

`ifdef VERMIBUS_ROUTER_TIMEOUT_EN
    task automatic test_timeout();
        tick();
        m_valid = 1'b1; m_address = 32'h2000_0000; s_ready = 3'b000;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++; if (m_ready !== 1'b0) begin n_fail++; $display("FAIL to_stall%0d_ready: got %b want 0", k, m_ready); end
            tick();
        end
        #1;
        n_checks++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL to_abort_ready: got %b want 1", m_ready); end
        n_checks++; if (m_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL to_abort_rdata: got %h want deadbeef", m_rdata); end
        n_checks++; if (s_valid !== 3'b000) begin n_fail++; $display("FAIL to_abort_s_valid: got %b want 000", s_valid); end
        tick();
        m_valid = 1'b0;
        #1;
        n_checks++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL to_flag: got %b want 1", err_timeout); end
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        #1;
        n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL to_flag_clear: got %b want 0", err_timeout); end
    endtask
`else
    task automatic test_no_timeout();
        int seen_ready;
        seen_ready = 0;
        tick();
        m_valid = 1'b1; m_address = 32'h2000_0000; s_ready = 3'b000;
        for (int k = 0; k < 1000; k++) begin
            #1;
            if (m_ready !== 1'b0) seen_ready++;
            tick();
        end
        #1;
        n_checks++; if (seen_ready !== 0) begin n_fail++; $display("FAIL nto_ready_count: got %0d want 0", seen_ready); end
        n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL nto_flag: got %b want 0", err_timeout); end
        n_checks++; if (s_valid !== 3'b100) begin n_fail++; $display("FAIL nto_s_valid: got %b want 100", s_valid); end
        m_valid = 1'b0;
        tick();
        m_valid = 1'b1; m_address = 32'h0000_0000;
        #1;
        n_checks++; if (s_valid !== 3'b001) begin n_fail++; $display("FAIL nto_drop_idle: got %b want 001", s_valid); end
        m_valid = 1'b0;
        #1;
    endtask
`endif

    task automatic test_reset_mid_wait();
        tick();
        m_valid = 1'b1; m_address = 32'h5000_0000; s_ready = 3'b000;
        tick();
        m_address = 32'h1000_0000;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; m_valid = 1'b0;
        #1;
        n_checks++; if (s_valid !== 3'b000) begin n_fail++; $display("FAIL rst_wait_s_valid: got %b want 000", s_valid); end
        n_checks++; if (m_ready !== 1'b0) begin n_fail++; $display("FAIL rst_wait_ready: got %b want 0", m_ready); end
        n_checks++; if (err_unmapped !== 1'b0) begin n_fail++; $display("FAIL rst_wait_flag: got %b want 0", err_unmapped); end
        m_valid = 1'b1; m_address = 32'h2000_0000;
        #1;
        n_checks++; if (s_valid !== 3'b100) begin n_fail++; $display("FAIL rst_wait_idle_route: got %b want 100", s_valid); end
        m_valid = 1'b0;
        #1;
    endtask

    task automatic test_duplicate_tags();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_valid = 1'b1; m_address = 32'h0000_0000; s_ready = 3'b011;
        #1;
        n_checks++; if (d2_s_valid !== 3'b001) begin n_fail++; $display("FAIL dup_s_valid: got %b want 001", d2_s_valid); end
        n_checks++; if (d2_m_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL dup_rdata: got %h want 12345678", d2_m_rdata); end
        n_checks++; if (d2_m_ready !== 1'b1) begin n_fail++; $display("FAIL dup_ready: got %b want 1", d2_m_ready); end
        tick();
        m_valid = 1'b0; s_ready = 3'b000;
        #1;
    endtask

    initial begin
        test_reset();
        test_ram_read();
        test_io_write();
        test_unmapped();
`ifdef VERMIBUS_ROUTER_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid_wait();
        test_duplicate_tags();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
